// File: rtl/pmd_timing_multiphase.sv
// PMD time-of-flight timing generator.
// Runs a frame of 1..MAX_PHASES sub-frames; each sub-frame is pixel reset,
// hold, modulated integration, serial ROI readout and a cooldown gap.
// Geometry, integration time and phase count are latched when a frame starts.
module pmd_timing_multiphase #(
  parameter int COL_W         = 8,
  parameter int ROW_W         = 8,
  parameter int MAX_PHASES    = 4,
  parameter int PH_W          = 2,
  parameter int T_CLK_HALF    = 25,
  parameter int T_PIXEL_RESET = 80,
  parameter int T_HOLD_RESET  = 10,
  parameter int T_HOLD_MOD    = 5,
  parameter int T_COOLDOWN    = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             abort,
  input  logic [31:0]      integration_time,
  input  logic [COL_W-1:0] last_column,
  input  logic [ROW_W-1:0] last_row,
  input  logic [PH_W-1:0]  num_phases_m1,
  input  logic             ENABLE_ROI,
  output logic             frame_rdy,
  output logic             mod_enable,
  output logic [PH_W-1:0]  phase_index,
  output logic [COL_W-1:0] current_column,
  output logic [ROW_W-1:0] current_row,
  output logic             sample_pixel,
  output logic             subframe_done,
  output logic             frame_done,
  output logic             roi_err,
  output logic             RESET_1,
  output logic             HOLD,
  output logic             START_ROI,
  output logic             CLK_ROI
);

  localparam int HC_W = (T_CLK_HALF > 1) ? $clog2(T_CLK_HALF) : 1;
  localparam logic [HC_W-1:0] HALF_LD = HC_W'(T_CLK_HALF - 1);
  localparam logic [31:0]     LD_PR   = 32'(T_PIXEL_RESET);
  localparam logic [31:0]     LD_HR   = 32'(T_HOLD_RESET);
  localparam logic [31:0]     LD_HM   = 32'(T_HOLD_MOD);
  localparam logic [31:0]     LD_CD   = 32'(T_COOLDOWN);
  localparam logic [PH_W-1:0] PH_MAX  = PH_W'(MAX_PHASES - 1);

  typedef enum logic [3:0] {
    IDLE, RST_A, RST_B, RST_C, INT_A, INT_B, INT_C, INT_D, INT_E,
    RD_START, RD_GAP, RD_PIX, COOLDOWN
  } state_t;

  // Saturate the requested phase count to what the frame supports.
  function automatic logic [PH_W-1:0] clamp_phases(input logic [PH_W-1:0] n);
    if (n > PH_MAX) return PH_MAX;
    return n;
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [HC_W-1:0]    half_q, half_d;
  logic               clk_roi_q, clk_roi_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               rep_q, rep_d;      // second CLK_ROI period of column 0
  logic [PH_W-1:0]    phase_q, phase_d;
  logic               roi_err_q, roi_err_d;
  logic               accept, sample_d, sub_done_d, frm_done_d;
  logic               tmr_done, half_done;
  logic               hold_d, reset1_d, mod_d, rdy_d, start_d;

  logic [31:0]        lat_int;
  logic [COL_W-1:0]   lat_col;
  logic [ROW_W-1:0]   lat_row;
  logic [PH_W-1:0]    lat_ph;

  assign tmr_done  = (cnt_q == 32'd0);
  assign half_done = (half_q == '0);

  // Next-state, counters and event strobes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = tmr_done ? cnt_q : cnt_q - 32'd1;
    half_d     = half_q;
    clk_roi_d  = clk_roi_q;
    col_d      = col_q;
    row_d      = row_q;
    rep_d      = rep_q;
    phase_d    = phase_q;
    accept     = 1'b0;
    sample_d   = 1'b0;
    sub_done_d = 1'b0;
    frm_done_d = 1'b0;
    case (state_q)
      IDLE: if (frame_start) begin
        accept  = 1'b1;
        state_d = RST_A;
        cnt_d   = LD_PR;
        phase_d = '0;
      end
      RST_A: if (tmr_done) begin state_d = RST_B; cnt_d = LD_HR; end
      RST_B: if (tmr_done) begin state_d = RST_C; cnt_d = LD_HR; end
      RST_C: if (tmr_done) begin state_d = INT_A; cnt_d = LD_HM; end
      INT_A: if (tmr_done) begin state_d = INT_B; cnt_d = lat_int; end
      INT_B: if (tmr_done) begin state_d = INT_C; cnt_d = LD_HM; end
      INT_C: if (tmr_done) begin state_d = INT_D; cnt_d = LD_HR; end
      INT_D: if (tmr_done) begin state_d = INT_E; cnt_d = LD_HR; end
      INT_E: if (tmr_done) begin
        state_d   = RD_START;
        half_d    = HALF_LD;
        clk_roi_d = 1'b1;
        col_d     = '0;
        row_d     = '0;
        rep_d     = 1'b0;
      end
      RD_START: if (half_done) begin
        half_d = HALF_LD;
        if (clk_roi_q) clk_roi_d = 1'b0;
        else           state_d   = RD_GAP;
      end else begin
        half_d = half_q - HC_W'(1);
      end
      RD_GAP: if (half_done) begin
        half_d    = HALF_LD;
        state_d   = RD_PIX;
        clk_roi_d = 1'b1;
      end else begin
        half_d = half_q - HC_W'(1);
      end
      RD_PIX: if (half_done) begin
        half_d = HALF_LD;
        if (clk_roi_q) begin
          // Falling edge: the sensor presents the pixel, strobe the sampler
          // except on the extra period of column 0.
          clk_roi_d = 1'b0;
          sample_d  = !rep_q;
        end else begin
          clk_roi_d = 1'b1;
          if (col_q == '0 && !rep_q) begin
            rep_d = 1'b1;
          end else begin
            rep_d = 1'b0;
            if (col_q == lat_col) begin
              col_d = '0;
              if (row_q == lat_row) begin
                row_d      = '0;
                clk_roi_d  = 1'b0;
                state_d    = COOLDOWN;
                cnt_d      = LD_CD;
                sub_done_d = 1'b1;
              end else begin
                row_d = row_q + ROW_W'(1);
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end else begin
        half_d = half_q - HC_W'(1);
      end
      COOLDOWN: if (tmr_done) begin
        if (phase_q < lat_ph) begin
          phase_d = phase_q + PH_W'(1);
          state_d = RST_A;
          cnt_d   = LD_PR;
        end else begin
          state_d    = IDLE;
          frm_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over every transition and suppresses all done pulses.
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      cnt_d      = '0;
      half_d     = '0;
      clk_roi_d  = 1'b0;
      col_d      = '0;
      row_d      = '0;
      rep_d      = 1'b0;
      phase_d    = '0;
      sample_d   = 1'b0;
      sub_done_d = 1'b0;
      frm_done_d = 1'b0;
    end
  end

  // Sticky ROI error: raised by a dropped ENABLE_ROI during readout.
  always_comb begin
    roi_err_d = roi_err_q;
    if (accept) roi_err_d = 1'b0;
    else if (!ENABLE_ROI &&
             (state_q == RD_START || state_q == RD_GAP || state_q == RD_PIX))
      roi_err_d = 1'b1;
  end

  // Sensor pin levels for the state being entered, registered below.
  always_comb begin
    hold_d   = 1'b1;
    reset1_d = 1'b1;
    mod_d    = 1'b0;
    rdy_d    = 1'b0;
    case (state_d)
      IDLE:         rdy_d    = 1'b1;
      RST_A:        hold_d   = 1'b0;
      RST_C:        reset1_d = 1'b0;
      INT_A, INT_C: begin hold_d = 1'b0; reset1_d = 1'b0; end
      INT_B:        begin hold_d = 1'b0; reset1_d = 1'b0; mod_d = 1'b1; end
      INT_D:        reset1_d = 1'b0;
      default:      ;
    endcase
    start_d = (state_d == RD_START) && clk_roi_d;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      half_q        <= '0;
      clk_roi_q     <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      rep_q         <= 1'b0;
      phase_q       <= '0;
      roi_err_q     <= 1'b0;
      HOLD          <= 1'b1;
      RESET_1       <= 1'b1;
      START_ROI     <= 1'b0;
      mod_enable    <= 1'b0;
      frame_rdy     <= 1'b1;
      sample_pixel  <= 1'b0;
      subframe_done <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      half_q        <= half_d;
      clk_roi_q     <= clk_roi_d;
      col_q         <= col_d;
      row_q         <= row_d;
      rep_q         <= rep_d;
      phase_q       <= phase_d;
      roi_err_q     <= roi_err_d;
      HOLD          <= hold_d;
      RESET_1       <= reset1_d;
      START_ROI     <= start_d;
      mod_enable    <= mod_d;
      frame_rdy     <= rdy_d;
      sample_pixel  <= sample_d;
      subframe_done <= sub_done_d;
      frame_done    <= frm_done_d;
    end
  end

  // Frame configuration snapshot; only meaningful while a frame runs.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_int <= integration_time;
      lat_col <= last_column;
      lat_row <= last_row;
      lat_ph  <= clamp_phases(num_phases_m1);
    end
  end

  assign CLK_ROI        = clk_roi_q;
  assign current_column = col_q;
  assign current_row    = row_q;
  assign phase_index    = phase_q;
  assign roi_err        = roi_err_q;

endmodule

// File: tb/tb_pmd_timing_multiphase.sv
// Directed bench for pmd_timing_multiphase with short timing parameters.
module tb_pmd_timing_multiphase;

  localparam int TCD = 6;

  logic        clk, reset, frame_start, abort, ENABLE_ROI;
  logic [31:0] integration_time;
  logic [7:0]  last_column, last_row, current_column, current_row;
  logic [1:0]  num_phases_m1, phase_index;
  logic        frame_rdy, mod_enable, sample_pixel, subframe_done, frame_done, roi_err;
  logic        RESET_1, HOLD, START_ROI, CLK_ROI;

  int n_tests = 0;
  int n_fail  = 0;

  pmd_timing_multiphase #(
    .COL_W(8), .ROW_W(8), .MAX_PHASES(3), .PH_W(2), .T_CLK_HALF(2),
    .T_PIXEL_RESET(3), .T_HOLD_RESET(1), .T_HOLD_MOD(1), .T_COOLDOWN(TCD)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .abort(abort),
    .integration_time(integration_time), .last_column(last_column),
    .last_row(last_row), .num_phases_m1(num_phases_m1), .ENABLE_ROI(ENABLE_ROI),
    .frame_rdy(frame_rdy), .mod_enable(mod_enable), .phase_index(phase_index),
    .current_column(current_column), .current_row(current_row),
    .sample_pixel(sample_pixel), .subframe_done(subframe_done),
    .frame_done(frame_done), .roi_err(roi_err), .RESET_1(RESET_1),
    .HOLD(HOLD), .START_ROI(START_ROI), .CLK_ROI(CLK_ROI)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  lc;
    logic [7:0]  lr;
    logic [1:0]  nph;
    logic [31:0] itime;
    bit          drop_roi;
    int          exp_samp;
    int          exp_sub;
    int          exp_mod;
    int          exp_rise;
    bit          exp_roi;
  } vec_t;

  vec_t tv[4];

  // {HOLD,RESET_1,START_ROI,CLK_ROI,mod_enable,frame_rdy,sample,subdone,framedone,roi_err}
  localparam logic [9:0] IDLE_PINS = 10'b11_0001_0000;

  function automatic logic [9:0] pins();
    return {HOLD, RESET_1, START_ROI, CLK_ROI, mod_enable, frame_rdy,
            sample_pixel, subframe_done, frame_done, roi_err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] lc, input logic [7:0] lr,
                             input logic [1:0] nph, input logic [31:0] it);
    @(negedge clk);
    last_column = lc; last_row = lr; num_phases_m1 = nph; integration_time = it;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      if (frame_done) got = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Runs one whole frame, corrupting config and pulsing frame_start mid-frame.
  task automatic run_vec(input int idx, input vec_t v);
    int n_samp, n_sub, n_mod, n_rise, order_err, phase_err, overlap, rdy_err;
    int since_sub, done_gap, sub_idx;
    logic [7:0] exp_r, exp_c;
    bit got, prev_clk, dropped, roi_low, roi_at_done;
    n_samp = 0; n_sub = 0; n_mod = 0; n_rise = 0; order_err = 0; phase_err = 0;
    overlap = 0; rdy_err = 0; since_sub = 0; done_gap = -1; sub_idx = 0;
    exp_r = 0; exp_c = 0; got = 0; dropped = 0; roi_low = 0; roi_at_done = 0;
    start_frame(v.lc, v.lr, v.nph, v.itime);
    chk($sformatf("v%0d roi_err cleared at start", idx), roi_err, 0);
    prev_clk = CLK_ROI;
    for (int cyc = 0; cyc < 4000 && !got; cyc++) begin
      since_sub++;
      if (sample_pixel) begin
        if (current_row != exp_r || current_column != exp_c) order_err++;
        n_samp++;
        if (exp_c == v.lc) begin exp_c = 0; exp_r++; end
        else exp_c++;
      end
      if (CLK_ROI && !prev_clk) n_rise++;
      prev_clk = CLK_ROI;
      if (mod_enable) n_mod++;
      if (frame_done) begin
        got = 1'b1;
        done_gap = since_sub;
        roi_at_done = roi_err;
        if (subframe_done) overlap++;
        if (!frame_rdy) rdy_err++;
      end else if (frame_rdy) rdy_err++;
      if (subframe_done) begin
        if (phase_index != 2'(sub_idx)) phase_err++;
        sub_idx++; n_sub++; exp_r = 0; exp_c = 0; since_sub = 0;
      end
      if (!got) begin
        if (roi_low) begin ENABLE_ROI = 1'b1; roi_low = 1'b0; end
        if (v.drop_roi && sample_pixel && !dropped) begin
          ENABLE_ROI = 1'b0; roi_low = 1'b1; dropped = 1'b1;
        end
        if (cyc == 3) begin
          last_column = ~v.lc; last_row = ~v.lr; num_phases_m1 = ~v.nph;
          integration_time = 32'h0000_ffff;
        end
        frame_start = (cyc == 5);
        @(negedge clk);
      end
    end
    frame_start = 1'b0;
    ENABLE_ROI = 1'b1;
    chk($sformatf("v%0d frame_done seen", idx), got, 1);
    chk($sformatf("v%0d sample count", idx), n_samp, v.exp_samp);
    chk($sformatf("v%0d pixel order errors", idx), order_err, 0);
    chk($sformatf("v%0d subframe_done count", idx), n_sub, v.exp_sub);
    chk($sformatf("v%0d phase_index at subframe_done", idx), phase_err, 0);
    chk($sformatf("v%0d mod_enable cycles", idx), n_mod, v.exp_mod);
    chk($sformatf("v%0d CLK_ROI rising edges", idx), n_rise, v.exp_rise);
    chk($sformatf("v%0d frame_done after last subframe_done", idx), done_gap, TCD + 1);
    chk($sformatf("v%0d done pulses overlap", idx), overlap, 0);
    chk($sformatf("v%0d frame_rdy while busy", idx), rdy_err, 0);
    chk($sformatf("v%0d roi_err at frame_done", idx), roi_at_done, v.exp_roi);
  endtask

  initial begin
    int n, viol;
    bit got;
    //          lc     lr     nph   itime  drop  samp sub mod rise roi
    tv[0] = '{8'd3, 8'd1, 2'd0, 32'd5, 1'b0,  8, 1, 6, 11, 1'b0};
    tv[1] = '{8'd0, 8'd2, 2'd2, 32'd0, 1'b1,  9, 3, 3, 21, 1'b1};
    tv[2] = '{8'd1, 8'd0, 2'd3, 32'd2, 1'b0,  6, 3, 9, 12, 1'b0};
    tv[3] = '{8'd2, 8'd2, 2'd1, 32'd1, 1'b0, 18, 2, 4, 26, 1'b0};

    reset = 1'b1; frame_start = 1'b0; abort = 1'b0; ENABLE_ROI = 1'b1;
    integration_time = 0; last_column = 0; last_row = 0; num_phases_m1 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset pins", pins(), IDLE_PINS);
    chk("reset indices", {phase_index, current_row, current_column}, 0);

    // Reset/hold/modulation edge spacing.
    start_frame(8'd3, 8'd1, 2'd0, 32'd5);
    n = 0;
    while (!HOLD && n < 50) begin n++; @(negedge clk); end
    chk("HOLD low cycles in pixel reset", n, 4);
    n = 0;
    while (RESET_1 && n < 50) begin n++; @(negedge clk); end
    chk("RESET_1 fall after HOLD rise", n, 2);
    n = 0;
    while (!mod_enable && n < 50) begin n++; @(negedge clk); end
    n = 0;
    while (mod_enable && n < 50) begin n++; @(negedge clk); end
    chk("mod_enable high cycles", n, 6);
    wait_done(got);
    chk("timing frame completes", got, 1);

    for (int i = 0; i < 4; i++) run_vec(i, tv[i]);

    // Abort in the second sub-frame's readout, after a busy frame_start.
    start_frame(8'd3, 8'd1, 2'd2, 32'd0);
    repeat (3) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("frame_rdy after busy frame_start", frame_rdy, 0);
    n = 0;
    while (!subframe_done && n < 500) begin n++; @(negedge clk); end
    @(negedge clk);
    n = 0;
    while (!sample_pixel && n < 500) begin n++; @(negedge clk); end
    chk("phase_index before abort", phase_index, 1);
    chk("sample before abort", sample_pixel, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("pins after abort", pins(), IDLE_PINS);
    chk("phase_index after abort", phase_index, 0);
    viol = 0;
    for (int i = 0; i < 60; i++) begin
      if (frame_done || sample_pixel || subframe_done || !frame_rdy || !HOLD) viol++;
      @(negedge clk);
    end
    chk("quiet after abort", viol, 0);

    // Asynchronous reset in the middle of integration.
    start_frame(8'd3, 8'd1, 2'd0, 32'd5);
    n = 0;
    while (!mod_enable && n < 50) begin n++; @(negedge clk); end
    chk("mod_enable before reset", mod_enable, 1);
    #1 reset = 1'b1;
    #1;
    chk("pins during async reset", pins(), IDLE_PINS);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("pins after reset release", pins(), IDLE_PINS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

endmodule
